tlbcam_plru: RTL and testbench
==============================

Name: tlbcam_plru

Overview:
- Fully associative TLB tag array: ENTRIES CAM lines with per-entry valid, ASID, global, NAPOT and page-type state.
- Adds three things over a single-line CAM: a configurable number of translation levels, sfence.vma-style selective flush, and tree pseudo-LRU victim selection.
- Sits in the MMU between the lookup request path and the page-table walker fill path.
- The matching PPN/permission RAM is external and indexed by HitIndex / VictimIndex.

Parameters:
ENTRIES, 16, number of lines; power of two, >=2
LEVELS, 4, page-table levels; 2 = Sv32, 3 = Sv39, 4 = Sv48, 5 = Sv57
SEGMENT_BITS, 9, VPN bits per level
ASID_BITS, 16, ASID width
NAPOT_EN, 1, enables the Svnapot 64 KiB match on level-0 entries

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ActiveLevels  in  $clog2(LEVELS+1)  levels in use this mode; VPN segments at index >= ActiveLevels are ignored
Lookup  in  1  lookup valid this cycle
VPN  in  LEVELS*SEGMENT_BITS  lookup and write VPN
ASID  in  ASID_BITS  lookup and write ASID
WriteEn  in  1  fill the line at VictimIndex
WrPageType  in  $clog2(LEVELS)  0 = 4 KiB, k = level-k superpage
WrGlobal  in  1  PTE G bit
WrNapot  in  1  PTE N bit with PPN[3:0] = 1000
Flush  in  1  sfence.vma
FlushVPNValid  in  1  rs1 != x0
FlushASIDValid  in  1  rs2 != x0
FlushVPN  in  LEVELS*SEGMENT_BITS  rs1 VPN
FlushASID  in  ASID_BITS  rs2 ASID
Hit  out  1  Lookup & any line match
HitIndex  out  ENTRIES  one-hot matching line(s), gated by Lookup
HitPageType  out  $clog2(LEVELS)  OR of page types of hit lines
VictimIndex  out  ENTRIES  one-hot line the next write fills
Full  out  1  all lines valid

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state: all Valid = 0 and all PLRU bits = 0. Outputs after reset: Hit = 0, HitIndex = 0, HitPageType = 0, Full = 0, VictimIndex = one-hot line 0.
- Key fields (Key, Global, Napot, PageType) are not reset.
- Line match requires all of:
  - Valid.
  - (stored ASID == ASID) | Global.
  - For each segment i: segment i equal, or i < PageType, or i >= ActiveLevels.
  - Level 0 additionally matches when NAPOT_EN & Napot & PageType == 0 & VPN[SEGMENT_BITS-1:4] equal.
- Lookup is combinational, zero latency, and sees state as of the start of the cycle. A write or flush in the same cycle becomes visible the next cycle.
- Multiple hits are illegal; the walker never fills a present translation. HitIndex may then be multi-hot and HitPageType is the OR of the hit lines; the bench asserts this never occurs.
- Write, registered at the clock edge:
  - The line at VictimIndex takes Key = {ASID, VPN}, Global = WrGlobal, Napot = WrNapot & NAPOT_EN, PageType = WrPageType, Valid = 1.
  - VictimIndex = lowest-index invalid line if any exists, else the PLRU victim.
- Flush, registered at the clock edge; a line is invalidated when:
  - Neither valid flag set: every line.
  - FlushASIDValid only: lines with !Global and ASID == FlushASID.
  - FlushVPNValid only: lines whose key matches FlushVPN using the line's own PageType, Napot and ActiveLevels (ASID ignored, global included).
  - Both set: lines meeting both conditions; global lines excluded.
  - Key fields are left unchanged on flush.
- Flush and WriteEn in the same cycle: flush is evaluated on the old state, then the write is applied. The written line ends valid even if it was flushed.
- Tree PLRU, ENTRIES-1 bits:
  - Node n has children 2n+1 (lower indices) and 2n+2.
  - Node bit = 0 means the victim lies in the lower subtree.
  - Victim = leaf reached by following the bits from the root.
  - Touching line e sets every node on its path to point away from e.
- PLRU updates: Lookup & Hit touches the hit line; WriteEn touches the written line. When both occur in one cycle, the hit touch is applied first and the write touch second, so the write wins on shared nodes. Flush does not alter the PLRU bits.
- Full = AND of all Valid bits.
- Reset asserted mid-operation overrides any write or flush in the same cycle.

Test Plan:
- ENTRIES=4, LEVELS=3, SEGMENT_BITS=9, ActiveLevels=3. Reset, then write VPN 0x1, 0x2, 0x3, 0x4, ASID 5, type 0 -> VictimIndex 0001, 0010, 0100, 1000 in turn; Full=1 after the 4th write.
- Lookup VPN 0x3 ASID 5 -> Hit=1, HitIndex=0100. ASID 6 -> Hit=0. Refill line 0 with VPN 0x00200 type 1 -> lookup 0x002FF hits with HitPageType=1; 0x00400 misses.
- PLRU after the 4 fills -> victim 0001. Lookup hit on line 0 -> victim 0100. Hit on line 2 -> victim 0010.
- Line 1 global (WrGlobal=1), others ASID 5. Flush with FlushASIDValid=1, FlushASID=5 -> only line 1 valid; Full=0; VictimIndex=0001. Then Flush with both flags clear -> all lines invalid.
- NAPOT: write VPN 0x1230 type 0 WrNapot=1 -> lookup 0x123F hits, 0x1240 misses. Repeat with NAPOT_EN=0 -> 0x123F misses.
- Same-cycle WriteEn (VPN 0x7) + full Flush -> only the new line valid next cycle, and a same-cycle lookup of 0x7 misses. Reset asserted together with WriteEn -> all invalid, VictimIndex=0001.

Source files
------------

// File: rtl/tlbcam_plru_if.sv
// Lookup, fill and flush signals between the MMU and the TLB tag CAM.
interface tlbcam_plru_if #(
  parameter int unsigned ENTRIES      = 16,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned SEGMENT_BITS = 9,
  parameter int unsigned ASID_BITS    = 16
);
  localparam int unsigned KeyW = LEVELS * SEGMENT_BITS;
  localparam int unsigned PtW  = $clog2(LEVELS);
  localparam int unsigned AlW  = $clog2(LEVELS + 1);

  logic [AlW-1:0]       ActiveLevels;
  logic                 Lookup;
  logic [KeyW-1:0]      VPN;
  logic [ASID_BITS-1:0] ASID;
  logic                 WriteEn;
  logic [PtW-1:0]       WrPageType;
  logic                 WrGlobal;
  logic                 WrNapot;
  logic                 Flush;
  logic                 FlushVPNValid;
  logic                 FlushASIDValid;
  logic [KeyW-1:0]      FlushVPN;
  logic [ASID_BITS-1:0] FlushASID;
  logic                 Hit;
  logic [ENTRIES-1:0]   HitIndex;
  logic [PtW-1:0]       HitPageType;
  logic [ENTRIES-1:0]   VictimIndex;
  logic                 Full;

  modport master (
    output ActiveLevels, Lookup, VPN, ASID, WriteEn, WrPageType, WrGlobal, WrNapot,
           Flush, FlushVPNValid, FlushASIDValid, FlushVPN, FlushASID,
    input  Hit, HitIndex, HitPageType, VictimIndex, Full
  );

  modport slave (
    input  ActiveLevels, Lookup, VPN, ASID, WriteEn, WrPageType, WrGlobal, WrNapot,
           Flush, FlushVPNValid, FlushASIDValid, FlushVPN, FlushASID,
    output Hit, HitIndex, HitPageType, VictimIndex, Full
  );
endinterface

// File: rtl/tlbcam_plru.sv
// Fully associative TLB tag CAM with multi-level page matching, selective
// sfence.vma flush and tree pseudo-LRU replacement.
module tlbcam_plru #(
  parameter int unsigned ENTRIES      = 16,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned SEGMENT_BITS = 9,
  parameter int unsigned ASID_BITS    = 16,
  parameter bit          NAPOT_EN     = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  tlbcam_plru_if.slave  bus
);
  localparam int unsigned KeyW = LEVELS * SEGMENT_BITS;
  localparam int unsigned PtW  = $clog2(LEVELS);
  localparam int unsigned AlW  = $clog2(LEVELS + 1);
  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-2:0]   plru_q, plru_d;
  logic [KeyW-1:0]      vpn_q    [ENTRIES];
  logic [ASID_BITS-1:0] asid_q   [ENTRIES];
  logic [PtW-1:0]       ptype_q  [ENTRIES];
  logic [ENTRIES-1:0]   global_q;
  logic [ENTRIES-1:0]   napot_q;

  logic [ENTRIES-1:0]   hit_vec, flush_vec;
  logic [PtW-1:0]       hit_pt;
  logic [IdxW-1:0]      hit_idx, victim_idx;

  // Segment-wise VPN compare; segments below the page level or above the
  // active level count are don't-care, NAPOT relaxes the low 4 bits of level 0.
  function automatic logic vpn_match(input logic [KeyW-1:0] stored,
                                     input logic [KeyW-1:0] vpn,
                                     input logic [PtW-1:0]  ptype,
                                     input logic            napot,
                                     input logic [AlW-1:0]  active);
    logic ok;
    logic seg_eq;
    ok = 1'b1;
    for (int i = 0; i < int'(LEVELS); i++) begin
      seg_eq = stored[i*SEGMENT_BITS +: SEGMENT_BITS] == vpn[i*SEGMENT_BITS +: SEGMENT_BITS];
      if (i == 0 && NAPOT_EN && napot && ptype == '0) begin
        seg_eq = seg_eq | (stored[SEGMENT_BITS-1:4] == vpn[SEGMENT_BITS-1:4]);
      end
      if (!(seg_eq || i < int'(ptype) || i >= int'(active))) ok = 1'b0;
    end
    return ok;
  endfunction

  // Point every tree node on the path to the given line away from it.
  function automatic logic [ENTRIES-2:0] touch(input logic [ENTRIES-2:0] bits,
                                               input logic [IdxW-1:0]    line);
    int node;
    node = 0;
    for (int d = 0; d < int'(IdxW); d++) begin
      bits[node] = ~line[IdxW-1-d];
      node = 2 * node + 1 + int'(line[IdxW-1-d]);
    end
    return bits;
  endfunction

  // Lookup and flush match vectors against the current state.
  always_comb begin
    hit_vec   = '0;
    hit_pt    = '0;
    hit_idx   = '0;
    flush_vec = '0;
    for (int e = 0; e < int'(ENTRIES); e++) begin
      if (valid_q[e] && (asid_q[e] == bus.ASID || global_q[e]) &&
          vpn_match(vpn_q[e], bus.VPN, ptype_q[e], napot_q[e], bus.ActiveLevels)) begin
        hit_vec[e] = bus.Lookup;
      end
      if (hit_vec[e]) begin
        hit_pt  = hit_pt | ptype_q[e];
        hit_idx = hit_idx | IdxW'(e);
      end
      flush_vec[e] = bus.Flush &
                     (!bus.FlushVPNValid ||
                      vpn_match(vpn_q[e], bus.FlushVPN, ptype_q[e], napot_q[e],
                                bus.ActiveLevels)) &
                     (!bus.FlushASIDValid || (!global_q[e] && asid_q[e] == bus.FlushASID));
    end
  end

  // Victim: lowest invalid line, else the leaf the PLRU tree points at.
  always_comb begin
    int  node;
    logic found;
    found      = 1'b0;
    victim_idx = '0;
    for (int e = int'(ENTRIES) - 1; e >= 0; e--) begin
      if (!valid_q[e]) begin
        victim_idx = IdxW'(e);
        found      = 1'b1;
      end
    end
    node = 0;
    for (int d = 0; d < int'(IdxW); d++) begin
      node = 2 * node + 1 + int'(plru_q[node]);
    end
    if (!found) victim_idx = IdxW'(node - int'(ENTRIES - 1));
  end

  // Next state: flush on old state then write; hit touch before write touch.
  always_comb begin
    valid_d = valid_q & ~flush_vec;
    plru_d  = plru_q;
    if (bus.Hit) plru_d = touch(plru_d, hit_idx);
    if (bus.WriteEn) begin
      valid_d[victim_idx] = 1'b1;
      plru_d              = touch(plru_d, victim_idx);
    end
  end

  // Valid and PLRU state; reset wins over any same-cycle write or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  // Key fields are not reset and survive flushes.
  always_ff @(posedge clk) begin
    if (!reset && bus.WriteEn) begin
      vpn_q[victim_idx]    <= bus.VPN;
      asid_q[victim_idx]   <= bus.ASID;
      ptype_q[victim_idx]  <= bus.WrPageType;
      global_q[victim_idx] <= bus.WrGlobal;
      napot_q[victim_idx]  <= bus.WrNapot & NAPOT_EN;
    end
  end

  assign bus.Hit         = |hit_vec;
  assign bus.HitIndex    = hit_vec;
  assign bus.HitPageType = hit_pt;
  assign bus.VictimIndex = ENTRIES'(1) << victim_idx;
  assign bus.Full        = &valid_q;
endmodule

// File: tb/tb_tlbcam_plru.sv
// Directed bench for tlbcam_plru: 4 entries, 3 levels, with a NAPOT-disabled twin.
module tb_tlbcam_plru;
  localparam int unsigned E = 4;
  localparam int unsigned L = 3;
  localparam int unsigned S = 9;
  localparam int unsigned A = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  tlbcam_plru_if #(.ENTRIES(E), .LEVELS(L), .SEGMENT_BITS(S), .ASID_BITS(A)) bus ();
  tlbcam_plru_if #(.ENTRIES(E), .LEVELS(L), .SEGMENT_BITS(S), .ASID_BITS(A)) bus2 ();

  tlbcam_plru #(.ENTRIES(E), .LEVELS(L), .SEGMENT_BITS(S), .ASID_BITS(A), .NAPOT_EN(1'b1))
    dut (.clk(clk), .reset(reset), .bus(bus));
  tlbcam_plru #(.ENTRIES(E), .LEVELS(L), .SEGMENT_BITS(S), .ASID_BITS(A), .NAPOT_EN(1'b0))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  // Multiple hits never happen in legal use.
  always @(negedge clk) begin
    if (bus.Lookup && !$onehot0(bus.HitIndex)) $error("FAIL multi_hit: HitIndex %b", bus.HitIndex);
  end

  task automatic idle();
    bus.ActiveLevels = 2'd3; bus.Lookup = 0; bus.VPN = '0; bus.ASID = '0;
    bus.WriteEn = 0; bus.WrPageType = '0; bus.WrGlobal = 0; bus.WrNapot = 0;
    bus.Flush = 0; bus.FlushVPNValid = 0; bus.FlushASIDValid = 0;
    bus.FlushVPN = '0; bus.FlushASID = '0;
    bus2.ActiveLevels = 2'd3; bus2.Lookup = 0; bus2.VPN = '0; bus2.ASID = '0;
    bus2.WriteEn = 0; bus2.WrPageType = '0; bus2.WrGlobal = 0; bus2.WrNapot = 0;
    bus2.Flush = 0; bus2.FlushVPNValid = 0; bus2.FlushASIDValid = 0;
    bus2.FlushVPN = '0; bus2.FlushASID = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic write_line(input logic [26:0] vpn, input logic [15:0] asid,
                            input logic [1:0] pt, input logic g, input logic n);
    bus.WriteEn = 1; bus.VPN = vpn; bus.ASID = asid;
    bus.WrPageType = pt; bus.WrGlobal = g; bus.WrNapot = n;
    @(posedge clk); #1;
    bus.WriteEn = 0; bus.WrGlobal = 0; bus.WrNapot = 0; bus.WrPageType = '0;
  endtask

  task automatic probe(input logic [26:0] vpn, input logic [15:0] asid);
    bus.Lookup = 1; bus.VPN = vpn; bus.ASID = asid;
    @(negedge clk);
  endtask

  // Drop the lookup before the edge so it does not touch the PLRU.
  task automatic drop();
    bus.Lookup = 0;
  endtask

  // Keep the lookup across the edge so a hit touches the PLRU.
  task automatic commit();
    @(posedge clk); #1;
    bus.Lookup = 0;
  endtask

  task automatic fill4(input logic g1);
    for (int i = 0; i < 4; i++) write_line(27'(i + 1), 16'd5, 2'd0, (i == 1) ? g1 : 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.Full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.Full); end
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL reset_victim: got %b want 0001", bus.VictimIndex); end
    n_cmp++; if (bus.HitPageType !== 2'd0) begin n_bad++; $display("FAIL reset_hpt: got %0d want 0", bus.HitPageType); end
    probe(27'h0, 16'd0);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0", bus.Hit); end
    n_cmp++; if (bus.HitIndex !== 4'b0000) begin n_bad++; $display("FAIL reset_hitidx: got %b want 0000", bus.HitIndex); end
    drop();
  endtask

  task automatic test_fill();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = 4'b0001 << i;
      n_cmp++; if (bus.VictimIndex !== exp) begin n_bad++; $display("FAIL fill_victim%0d: got %b want %b", i, bus.VictimIndex, exp); end
      write_line(27'(i + 1), 16'd5, 2'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    n_cmp++; if (bus.Full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", bus.Full); end
  endtask

  task automatic test_lookup();
    probe(27'h3, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b1) begin n_bad++; $display("FAIL lk_hit: got %b want 1", bus.Hit); end
    n_cmp++; if (bus.HitIndex !== 4'b0100) begin n_bad++; $display("FAIL lk_idx: got %b want 0100", bus.HitIndex); end
    drop();
    probe(27'h3, 16'd6);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL lk_asid: got %b want 0", bus.Hit); end
    drop();
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL lk_victim: got %b want 0001", bus.VictimIndex); end
    write_line(27'h00200, 16'd5, 2'd1, 1'b0, 1'b0);
    probe(27'h002FF, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b1) begin n_bad++; $display("FAIL lk_super_hit: got %b want 1", bus.Hit); end
    n_cmp++; if (bus.HitIndex !== 4'b0001) begin n_bad++; $display("FAIL lk_super_idx: got %b want 0001", bus.HitIndex); end
    n_cmp++; if (bus.HitPageType !== 2'd1) begin n_bad++; $display("FAIL lk_super_pt: got %0d want 1", bus.HitPageType); end
    drop();
    probe(27'h00400, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL lk_super_miss: got %b want 0", bus.Hit); end
    drop();
  endtask

  task automatic test_plru();
    do_reset();
    fill4(1'b0);
    @(negedge clk);
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL plru_init: got %b want 0001", bus.VictimIndex); end
    probe(27'h1, 16'd5); commit();
    @(negedge clk);
    n_cmp++; if (bus.VictimIndex !== 4'b0100) begin n_bad++; $display("FAIL plru_hit0: got %b want 0100", bus.VictimIndex); end
    probe(27'h3, 16'd5); commit();
    @(negedge clk);
    n_cmp++; if (bus.VictimIndex !== 4'b0010) begin n_bad++; $display("FAIL plru_hit2: got %b want 0010", bus.VictimIndex); end
  endtask

  // Hit on line 3 and write to line 1 in one cycle: the write touch must win.
  task automatic test_back_to_back();
    probe(27'h4, 16'd5);
    bus.WriteEn = 1;
    commit();
    bus.WriteEn = 0;
    @(negedge clk);
    n_cmp++; if (bus.VictimIndex !== 4'b0100) begin n_bad++; $display("FAIL b2b_order: got %b want 0100", bus.VictimIndex); end
  endtask

  task automatic test_flush();
    do_reset();
    fill4(1'b1);
    bus.Flush = 1; bus.FlushASIDValid = 1; bus.FlushASID = 16'd5;
    @(posedge clk); #1;
    bus.Flush = 0; bus.FlushASIDValid = 0;
    @(negedge clk);
    n_cmp++; if (bus.Full !== 1'b0) begin n_bad++; $display("FAIL fl_asid_full: got %b want 0", bus.Full); end
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL fl_asid_victim: got %b want 0001", bus.VictimIndex); end
    probe(27'h2, 16'd9);
    n_cmp++; if (bus.HitIndex !== 4'b0010) begin n_bad++; $display("FAIL fl_global_kept: got %b want 0010", bus.HitIndex); end
    drop();
    probe(27'h1, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL fl_asid_gone: got %b want 0", bus.Hit); end
    drop();
    bus.Flush = 1;
    @(posedge clk); #1;
    bus.Flush = 0;
    probe(27'h2, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL fl_all: got %b want 0", bus.Hit); end
    drop();
    write_line(27'h00200, 16'd5, 2'd1, 1'b0, 1'b0);
    write_line(27'h00005, 16'd5, 2'd0, 1'b0, 1'b0);
    bus.Flush = 1; bus.FlushVPNValid = 1; bus.FlushVPN = 27'h002AB;
    @(posedge clk); #1;
    bus.Flush = 0; bus.FlushVPNValid = 0;
    @(negedge clk);
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL fl_vpn_victim: got %b want 0001", bus.VictimIndex); end
    probe(27'h5, 16'd5);
    n_cmp++; if (bus.HitIndex !== 4'b0010) begin n_bad++; $display("FAIL fl_vpn_kept: got %b want 0010", bus.HitIndex); end
    drop();
  endtask

  task automatic test_napot();
    do_reset();
    write_line(27'h1230, 16'd5, 2'd0, 1'b0, 1'b1);
    bus2.WriteEn = 1; bus2.VPN = 27'h1230; bus2.ASID = 16'd5; bus2.WrNapot = 1;
    @(posedge clk); #1;
    bus2.WriteEn = 0; bus2.WrNapot = 0;
    probe(27'h123F, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b1) begin n_bad++; $display("FAIL napot_hit: got %b want 1", bus.Hit); end
    drop();
    probe(27'h1240, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL napot_miss: got %b want 0", bus.Hit); end
    drop();
    bus2.Lookup = 1; bus2.VPN = 27'h123F;
    @(negedge clk);
    n_cmp++; if (bus2.Hit !== 1'b0) begin n_bad++; $display("FAIL napot_off: got %b want 0", bus2.Hit); end
    bus2.VPN = 27'h1230;
    @(negedge clk);
    n_cmp++; if (bus2.Hit !== 1'b1) begin n_bad++; $display("FAIL napot_off_exact: got %b want 1", bus2.Hit); end
    bus2.Lookup = 0;
  endtask

  task automatic test_write_flush();
    do_reset();
    write_line(27'h1, 16'd5, 2'd0, 1'b0, 1'b0);
    write_line(27'h2, 16'd5, 2'd0, 1'b0, 1'b0);
    bus.WriteEn = 1; bus.Flush = 1; bus.Lookup = 1; bus.VPN = 27'h7; bus.ASID = 16'd5;
    @(negedge clk);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL wf_same_cycle: got %b want 0", bus.Hit); end
    @(posedge clk); #1;
    bus.WriteEn = 0; bus.Flush = 0; bus.Lookup = 0;
    probe(27'h7, 16'd5);
    n_cmp++; if (bus.HitIndex !== 4'b0100) begin n_bad++; $display("FAIL wf_new_line: got %b want 0100", bus.HitIndex); end
    drop();
    probe(27'h1, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL wf_old_gone: got %b want 0", bus.Hit); end
    drop();
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL wf_victim: got %b want 0001", bus.VictimIndex); end
    reset = 1; bus.WriteEn = 1; bus.VPN = 27'h8;
    @(posedge clk); #1;
    reset = 0; bus.WriteEn = 0;
    probe(27'h8, 16'd5);
    n_cmp++; if (bus.Hit !== 1'b0) begin n_bad++; $display("FAIL rst_write_hit: got %b want 0", bus.Hit); end
    n_cmp++; if (bus.VictimIndex !== 4'b0001) begin n_bad++; $display("FAIL rst_write_victim: got %b want 0001", bus.VictimIndex); end
    n_cmp++; if (bus.Full !== 1'b0) begin n_bad++; $display("FAIL rst_write_full: got %b want 0", bus.Full); end
    drop();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_lookup();
    test_plru();
    test_back_to_back();
    test_flush();
    test_napot();
    test_write_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
